ntt_dit_stage_ctrl: RTL

Sequencer for in-place radix-2 DIT NTT passes over a single-port-read/single-port-write coefficient RAM pair. It sits directly upstream of the DIT butterfly datapath. Each cycle it issues coefficient-pair read addresses, the matching twiddle-ROM address and the butterfly mode. It then replays the same addresses, delayed to match RAM plus butterfly latency, as write-back addresses. It also supports a pointwise scale pass that uses the butterfly's multiply-B mode.

---
 rtl/ntt_dit_stage_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ntt_dit_stage_ctrl.sv
// Address/strobe sequencer for in-place radix-2 DIT NTT passes and scale pass.
// Ports: clk, reset (sync, active-high), start/op in; busy/done status;
// rd_en, rd_addr_a/b, tw_addr read side; bf_mode butterfly mode;
// wr_en_a/b, wr_addr_a/b write-back side; stage index.

`ifndef INTMUL_DELAY
`define INTMUL_DELAY 2
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 1
`endif

module ntt_dit_stage_ctrl #(
   parameter int LOGN       = 10,
   parameter int RD_LATENCY = 1,
   parameter int BF_LATENCY = `INTMUL_DELAY + `MODRED_DELAY + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            op,
   output logic            busy,
   output logic            done,
   output logic            rd_en,
   output logic [LOGN-1:0] rd_addr_a,
   output logic [LOGN-1:0] rd_addr_b,
   output logic [LOGN-1:0] tw_addr,
   output logic            bf_mode,
   output logic            wr_en_a,
   output logic            wr_en_b,
   output logic [LOGN-1:0] wr_addr_a,
   output logic [LOGN-1:0] wr_addr_b,
   output logic [LOGN-1:0] stage
);

   localparam int D = RD_LATENCY + BF_LATENCY;
   localparam logic [LOGN-1:0] ONE        = LOGN'(1);
   localparam logic [LOGN-1:0] LAST_PAIR  = LOGN'((1 << (LOGN - 1)) - 1);
   localparam logic [LOGN-1:0] LAST_ELEM  = LOGN'((1 << LOGN) - 1);
   localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state_q;
   logic            op_q;
   logic [LOGN-1:0] cnt_q;
   logic [LOGN-1:0] stage_q;
   logic            busy_q;
   logic            done_q;
   logic            rd_en_q;
   logic [LOGN-1:0] ra_q;
   logic [LOGN-1:0] rb_q;
   logic [LOGN-1:0] tw_q;

   logic [D-1:0]          pv_q;
   logic [D-1:0]          pf_q;
   logic [LOGN-1:0]       pa_q [D];
   logic [LOGN-1:0]       pb_q [D];
   logic [RD_LATENCY-1:0] mode_q;

   logic [LOGN-1:0] iss_j_d;
   logic [LOGN-1:0] iss_s_d;
   logic            iss_op_d;
   logic [LOGN-1:0] ra_d;
   logic [LOGN-1:0] rb_d;
   logic [LOGN-1:0] tw_d;
   logic            last_d;
   logic            issue_d;
   logic            more_d;
   logic            empty_d;

   // Base of the butterfly group plus offset within it.
   function automatic logic [LOGN-1:0] pair_a(
      input logic [LOGN-1:0] j,
      input logic [LOGN-1:0] s
   );
      logic [LOGN-1:0] mask;
      mask = (ONE << s) - ONE;
      return ((j >> s) << (s + ONE)) | (j & mask);
   endfunction

   function automatic logic [LOGN-1:0] pair_tw(
      input logic [LOGN-1:0] j,
      input logic [LOGN-1:0] s
   );
      logic [LOGN-1:0] mask;
      mask = (ONE << s) - ONE;
      return (j & mask) << (LAST_STAGE - s);
   endfunction

   // Tail entry is being written this cycle, so it does not block the
   // next stage: its first read lands the cycle after the last write.
   always_comb begin
      empty_d = ~rd_en_q;
      for (int k = 0; k < D - 1; k++) begin
         empty_d = empty_d & ~pv_q[k];
      end
   end

   always_comb begin
      iss_j_d  = cnt_q;
      iss_s_d  = stage_q;
      iss_op_d = op_q;
      more_d   = ~op_q & (stage_q != LAST_STAGE);
      issue_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            iss_j_d  = '0;
            iss_s_d  = '0;
            iss_op_d = op;
            issue_d  = start;
         end
         S_ISSUE: begin
            issue_d = 1'b1;
         end
         S_DRAIN: begin
            iss_j_d = '0;
            iss_s_d = stage_q + ONE;
            issue_d = empty_d & more_d;
         end
         default: ;
      endcase
      if (iss_op_d) begin
         ra_d   = '0;
         rb_d   = iss_j_d;
         tw_d   = iss_j_d;
         last_d = (iss_j_d == LAST_ELEM);
      end else begin
         ra_d   = pair_a(iss_j_d, iss_s_d);
         rb_d   = ra_d + (ONE << iss_s_d);
         tw_d   = pair_tw(iss_j_d, iss_s_d);
         last_d = (iss_j_d == LAST_PAIR);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         cnt_q   <= '0;
         stage_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         ra_q    <= '0;
         rb_q    <= '0;
         tw_q    <= '0;
      end else begin
         rd_en_q <= issue_d;
         done_q  <= 1'b0;
         if (issue_d) begin
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            tw_q  <= tw_d;
            cnt_q <= last_d ? '0 : iss_j_d + ONE;
         end
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  stage_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= last_d ? S_DRAIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (last_d) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (empty_d) begin
                  if (more_d) begin
                     stage_q <= iss_s_d;
                     state_q <= last_d ? S_DRAIN : S_ISSUE;
                  end else begin
                     stage_q <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Write-back replay; the scale pass writes A_out to the element index.
   always_ff @(posedge clk) begin
      if (reset) begin
         pv_q   <= '0;
         pf_q   <= '0;
         mode_q <= '0;
         for (int k = 0; k < D; k++) begin
            pa_q[k] <= '0;
            pb_q[k] <= '0;
         end
      end else begin
         pv_q[0]   <= rd_en_q;
         pf_q[0]   <= op_q;
         pa_q[0]   <= op_q ? rb_q : ra_q;
         pb_q[0]   <= rb_q;
         mode_q[0] <= rd_en_q & op_q;
         for (int k = 1; k < D; k++) begin
            pv_q[k] <= pv_q[k-1];
            pf_q[k] <= pf_q[k-1];
            pa_q[k] <= pa_q[k-1];
            pb_q[k] <= pb_q[k-1];
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            mode_q[k] <= mode_q[k-1];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = ra_q;
   assign rd_addr_b = rb_q;
   assign tw_addr   = tw_q;
   assign stage     = stage_q;
   assign bf_mode   = mode_q[RD_LATENCY-1];
   assign wr_en_a   = pv_q[D-1];
   assign wr_en_b   = pv_q[D-1] & ~pf_q[D-1];
   assign wr_addr_a = pa_q[D-1];
   assign wr_addr_b = pb_q[D-1];

endmodule
